// File: rtl/cnn_sched_pkg.sv
// cnn_sched_pkg
// Shared definitions for the CNN job scheduler.
// Contents:
//   sched_state_t : 5-bit scheduler state encoding (IDLE, GRANT, LAUNCH, WAIT,
//                   RETIRE, ABORT). The width and binary style follow the CNN
//                   controller, so one state decoder works for both blocks.
package cnn_sched_pkg;

  typedef enum logic [4:0] {
    IDLE   = 5'd0,
    GRANT  = 5'd1,
    LAUNCH = 5'd2,
    WAIT   = 5'd3,
    RETIRE = 5'd4,
    ABORT  = 5'd5
  } sched_state_t;

endpackage

// File: rtl/cnn_job_scheduler_if.sv
// cnn_job_scheduler_if
// Bundles the requester side and the CNN engine side of the job scheduler.
// Parameters: R (requesters), AW (address width).
// Signals:
//   req      requester -> sched  per-requester job request (level)
//   req_src  requester -> sched  packed source bases, slice i = requester i
//   req_dst  requester -> sched  packed destination bases
//   gnt      sched -> requester  one-hot acceptance pulse
//   fin      sched -> requester  one-hot completion pulse
//   err      sched -> requester  one-hot timeout pulse
//   cnn_start sched -> engine    one-cycle start pulse
//   cnn_src/cnn_dst sched -> engine latched base addresses
//   cnn_done engine -> sched     one-cycle done pulse
//   busy, owner, state           status and debug view of the scheduler
// Handshake: req is a level that the requester holds (with its addresses)
// until it sees its gnt bit; gnt, fin, err, cnn_start and cnn_done are all
// single-cycle pulses with no back-pressure, and cnn_done only counts while
// the scheduler is in WAIT.
// Modports: slave = scheduler, master = requesters plus engine environment.
interface cnn_job_scheduler_if #(
  parameter int R  = 4,
  parameter int AW = 16
);
  import cnn_sched_pkg::*;

  localparam int IW = $clog2(R);

  logic [R-1:0]    req;
  logic [R*AW-1:0] req_src;
  logic [R*AW-1:0] req_dst;
  logic [R-1:0]    gnt;
  logic [R-1:0]    fin;
  logic [R-1:0]    err;
  logic            cnn_start;
  logic [AW-1:0]   cnn_src;
  logic [AW-1:0]   cnn_dst;
  logic            cnn_done;
  logic            busy;
  logic [IW-1:0]   owner;
  sched_state_t    state;

  modport slave (
    input  req, req_src, req_dst, cnn_done,
    output gnt, fin, err, cnn_start, cnn_src, cnn_dst, busy, owner, state
  );

  modport master (
    output req, req_src, req_dst, cnn_done,
    input  gnt, fin, err, cnn_start, cnn_src, cnn_dst, busy, owner, state
  );

endinterface

// File: rtl/cnn_job_scheduler_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin pick: the first set req bit found when
// searching upward from ptr, wrapping modulo R.
// Ports:
//   req   in  R          request vector
//   ptr   in  $clog2(R)  index with highest priority this round
//   grant out R          one-hot winner (all zero when req is zero)
//   idx   out $clog2(R)  index of the winner (zero when req is zero)
module rr_arbiter #(
  parameter  int R  = 4,
  localparam int IW = $clog2(R)
) (
  input  logic [R-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [R-1:0]  grant,
  output logic [IW-1:0] idx
);

  int   pos;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int i = 0; i < R; i++) begin
      pos = int'(ptr) + i;
      if (pos >= R) pos = pos - R;
      if (!found && req[IW'(pos)]) begin
        found              = 1'b1;
        grant[IW'(pos)]    = 1'b1;
        idx                = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/cnn_job_scheduler.sv
// cnn_job_scheduler
// Shares one CNN convolution engine between R requesters. A round-robin
// arbiter picks one job, its source/destination bases are latched, the
// engine is started, and completion is reported back to the owner.
// Parameters: R (2..16), AW (address width), TIMEOUT (watchdog limit).
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-low reset
//   bus  cnn_job_scheduler_if.slave (requester and engine signals)
// Build option: define SCHED_WATCHDOG_EN to add a WAIT-cycle watchdog that
// aborts a job after TIMEOUT cycles and pulses err to its owner. Without it
// err is constant zero and WAIT lasts until cnn_done.
// Every output is a register (or a direct copy of one), so no input reaches
// an output combinationally.
module cnn_job_scheduler
  import cnn_sched_pkg::*;
#(
  parameter int R       = 4,
  parameter int AW      = 16,
  parameter int TIMEOUT = 4096
) (
  input logic              clk,
  input logic              rst,
  cnn_job_scheduler_if.slave bus
);

  localparam int IW = $clog2(R);

  if (R < 2 || R > 16 || TIMEOUT < 1) begin : g_bad_param
    $error("cnn_job_scheduler: R must be 2..16 and TIMEOUT at least 1");
  end

  sched_state_t  state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] ptr_next;
  logic [IW-1:0] win_idx;
  logic [R-1:0]  win_oh;
  logic [R-1:0]  owner_oh;
  logic [R-1:0]  gnt;
  logic [R-1:0]  fin;
  logic [R-1:0]  err;
  logic [AW-1:0] src_sel;
  logic [AW-1:0] dst_sel;
  logic [AW-1:0] cnn_src;
  logic [AW-1:0] cnn_dst;
  logic          cnn_start;
  logic          busy;

  rr_arbiter #(.R(R)) u_arb (
    .req   (bus.req),
    .ptr   (ptr),
    .grant (win_oh),
    .idx   (win_idx)
  );

  assign owner_oh = {{(R-1){1'b0}}, 1'b1} << owner;
  assign ptr_next = (owner == IW'(R - 1)) ? '0 : owner + IW'(1);

  // Owner's address slices; only sampled in GRANT, when owner is settled.
  always_comb begin
    src_sel = '0;
    dst_sel = '0;
    for (int i = 0; i < R; i++) begin
      if (owner == IW'(i)) begin
        src_sel = bus.req_src[i*AW +: AW];
        dst_sel = bus.req_dst[i*AW +: AW];
      end
    end
  end

`ifdef SCHED_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_cnt;
  logic [WW-1:0] wd_inc;
  assign wd_inc = wd_cnt + WW'(1);
`else
  assign err = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnn_src   <= '0;
      cnn_dst   <= '0;
      gnt       <= '0;
      fin       <= '0;
      cnn_start <= 1'b0;
      busy      <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
      err       <= '0;
      wd_cnt    <= '0;
`endif
    end else begin
      // Pulses default low; each state raises only the one it owns.
      gnt       <= '0;
      fin       <= '0;
      cnn_start <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
      err       <= '0;
`endif
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            state <= GRANT;
            owner <= win_idx;
            gnt   <= win_oh;
            busy  <= 1'b1;
          end
        end
        GRANT: begin
          // Addresses are captured here and held until the next grant.
          state     <= LAUNCH;
          cnn_src   <= src_sel;
          cnn_dst   <= dst_sel;
          cnn_start <= 1'b1;
        end
        LAUNCH: begin
          state  <= WAIT;
`ifdef SCHED_WATCHDOG_EN
          wd_cnt <= '0;
`endif
        end
        WAIT: begin
`ifdef SCHED_WATCHDOG_EN
          wd_cnt <= wd_inc;
`endif
          // Done is checked first so it beats a same-cycle timeout.
          if (bus.cnn_done) begin
            state <= RETIRE;
            fin   <= owner_oh;
          end
`ifdef SCHED_WATCHDOG_EN
          else if (wd_inc == WW'(TIMEOUT)) begin
            state <= ABORT;
            err   <= owner_oh;
          end
`endif
        end
        RETIRE: begin
          state <= IDLE;
          busy  <= 1'b0;
          ptr   <= ptr_next;
        end
`ifdef SCHED_WATCHDOG_EN
        ABORT: begin
          state <= IDLE;
          busy  <= 1'b0;
          ptr   <= ptr_next;
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt;
  assign bus.fin       = fin;
  assign bus.err       = err;
  assign bus.cnn_start = cnn_start;
  assign bus.cnn_src   = cnn_src;
  assign bus.cnn_dst   = cnn_dst;
  assign bus.busy      = busy;
  assign bus.owner     = owner;
  assign bus.state     = state;

endmodule
